idli_sqi_rdbuf_m: RTL and testbench
===================================

Name: idli_sqi_rdbuf_m

Overview:
Parametrised receive buffer for nibbles read back from SQI memory. It assembles an arbitrary number of nibbles per word and queues completed words in a small FIFO. The FIFO feeds fetch/decode through a valid/accept handshake. It replaces the single-nibble capture flop in the core top level and sits between idli_ctrl_m's read-valid strobe and the decode stage. It adds backpressure towards the SQI controller, overflow detection and flush on PC redirect.

Parameters:
NIBBLES, 4, nibbles per assembled word; word width W = 4*NIBBLES; must be >= 1.
DEPTH, 2, FIFO entries; must be >= 1.

Ports:
i_rdbuf_gck  in  1  core clock
i_rdbuf_rst_n  in  1  synchronous active-low reset
i_rdbuf_flush  in  1  discard partial word and all queued words (PC redirect)
i_rdbuf_sqi_vld  in  1  i_rdbuf_sqi_data valid this cycle (ctrl read-valid strobe)
i_rdbuf_sqi_data  in  4  nibble from SQI memory
o_rdbuf_sqi_rdy  out  1  FIFO has a free entry; ctrl may start a new word
o_rdbuf_data  out  W  head-of-FIFO word
o_rdbuf_vld  out  1  FIFO non-empty
i_rdbuf_acp  in  1  consumer accepts head
o_rdbuf_level  out  $clog2(DEPTH+1)  queued word count
o_rdbuf_ovf  out  1  sticky overflow flag

Behaviour:
- Single clock i_rdbuf_gck. Reset is synchronous and active-low on i_rdbuf_rst_n, sampled at posedge.
- Reset values:
  - level = 0, vld = 0, ovf = 0, rdy = 1.
  - Nibble counter = 0; read/write pointers = 0.
  - o_rdbuf_data is don't-care while vld = 0 and holds the head entry otherwise. Storage itself is not reset.
- Capture: at each posedge with sqi_vld = 1, the nibble is taken into the assembly register and the nibble counter increments.
  - Nibbles arrive MSB-first: the first nibble of a word becomes bits [W-1:W-4], the last becomes [3:0].
  - Gaps (sqi_vld = 0) between nibbles are allowed; the counter holds.
- Word completion: at the edge capturing nibble NIBBLES-1, the full word {assembled, nibble} is pushed directly into the FIFO and the counter wraps to 0.
  - o_rdbuf_vld / data reflect the new word in the cycle immediately after that edge. There is no extra latency.
- Pop: at a posedge with vld = 1 and acp = 1, the head is removed. acp while vld = 0 is ignored.
- Simultaneous push and pop:
  - Level is unchanged and both take effect.
  - Legal when full; no overflow results.
  - When level = 1, the new word becomes head next cycle.
- Overflow: a completing push with level = DEPTH and no pop in the same edge causes:
  - the word to be dropped;
  - FIFO contents, pointers and level to be unchanged;
  - ovf to set and remain 1 until reset. Flush does not clear it.
- o_rdbuf_sqi_rdy = (level < DEPTH), combinational from registered level. The controller must only begin a new word while rdy = 1. The block does not stall nibbles already in flight.
- Flush: at a posedge with flush = 1, level, pointers and nibble counter go to 0.
  - A nibble, push or pop presented in the same cycle is discarded or ignored. Flush has priority over everything.
  - vld = 0 in the following cycle.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Reset asserted mid-word or with data queued returns every state element to its reset value at that edge. Reset has priority over flush.

Decomposition:
- idli_pkg gains:
  - constant SQI_NIBBLE_W = 4;
  - typedef sqi_nibble_t = logic [SQI_NIBBLE_W-1:0].
- Port widths of i_rdbuf_sqi_data use sqi_nibble_t.
- One sub-module: idli_fifo_m, a generic W x DEPTH synchronous FIFO.
  - Interfaces: push/pop/flush, level, full/empty.
  - Reusable for the planned din/dout interfaces.
- Assembly counter, shift register and overflow flag stay in idli_sqi_rdbuf_m.

Test Plan:
1. Reset (NIBBLES=4, DEPTH=2): hold rst_n=0 two cycles -> vld=0, level=0, ovf=0, rdy=1 after the first sampled edge.
2. Back-to-back nibbles A,B,C,D with sqi_vld=1, acp=0 -> cycle after D: vld=1, data=16'hABCD, level=1, rdy=1.
3. Gapped nibbles 1,-,2,3,-,-,4 -> data=16'h1234 exactly one cycle after 4; vld stays 0 before that.
4. Overflow and push/pop when full:
   - Push 16'h1111 and 16'h2222 with acp=0 -> level=2, rdy=0.
   - Third word 16'h3333 with acp=0 -> ovf=1, head 16'h1111, level=2.
   - Repeat from reset with acp=1 on the completing edge -> ovf=0, head 16'h2222, level=2.
5. Flush mid-word and with queued data:
   - Queue 16'hABCD, send nibbles E,F, assert flush -> next cycle vld=0, level=0.
   - Then nibbles 5,6,7,8 -> data=16'h5678. A nibble sent in the flush cycle itself is lost.
6. NIBBLES=2, DEPTH=3: stream bytes 8'h01..8'h0A, acp toggling 1,0,1,0 -> output order 01..0A exactly, no ovf, pointers wrap at least twice, level never exceeds 3.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// Anything crossing a unit boundary lives here.
package idli_pkg;

    localparam int SQI_NIBBLE_W = 4;

    typedef logic [SQI_NIBBLE_W-1:0] sqi_nibble_t;

endpackage

// File: rtl/idli_fifo_m.sv
// Generic W x DEPTH synchronous FIFO with flush and occupancy level.
// Head is read combinationally; DEPTH need not be a power of two.
module idli_fifo_m #(
    parameter  int W     = 16,
    parameter  int DEPTH = 2,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot, so a push into a full FIFO is still legal.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/idli_sqi_rdbuf_m.sv
// SQI read buffer: assembles MSB-first nibbles into words and
// queues them for fetch/decode with overflow detection and flush.
module idli_sqi_rdbuf_m
    import idli_pkg::*;
#(
    parameter  int NIBBLES = 4,
    parameter  int DEPTH   = 2,
    localparam int W       = SQI_NIBBLE_W * NIBBLES,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic          i_rdbuf_gck,
    input  logic          i_rdbuf_rst_n,
    input  logic          i_rdbuf_flush,
    input  logic          i_rdbuf_sqi_vld,
    input  sqi_nibble_t   i_rdbuf_sqi_data,
    output logic          o_rdbuf_sqi_rdy,
    output logic [W-1:0]  o_rdbuf_data,
    output logic          o_rdbuf_vld,
    input  logic          i_rdbuf_acp,
    output logic [LW-1:0] o_rdbuf_level,
    output logic          o_rdbuf_ovf
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  asm_q;
    logic [W-1:0]  word;
    logic          push;
    logic          pop_ok;
    logic          full;
    logic          empty;

    // Older nibbles shift out the top, so no clear is needed between words.
    assign word   = (asm_q << SQI_NIBBLE_W) | W'(i_rdbuf_sqi_data);
    assign push   = i_rdbuf_sqi_vld && (cnt == LAST) && !i_rdbuf_flush;
    assign pop_ok = i_rdbuf_acp && !empty;

    assign o_rdbuf_vld     = !empty;
    assign o_rdbuf_sqi_rdy = !full;

    always_ff @(posedge i_rdbuf_gck) begin
        if (!i_rdbuf_rst_n) begin
            cnt         <= '0;
            asm_q       <= '0;
            o_rdbuf_ovf <= 1'b0;
        end else begin
            if (push && full && !pop_ok) begin
                o_rdbuf_ovf <= 1'b1;
            end
            if (i_rdbuf_flush) begin
                cnt <= '0;
            end else if (i_rdbuf_sqi_vld) begin
                asm_q <= word;
                cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
        end
    end

    idli_fifo_m #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_rdbuf_gck),
        .rst_n     (i_rdbuf_rst_n),
        .flush     (i_rdbuf_flush),
        .push      (push),
        .push_data (word),
        .pop       (i_rdbuf_acp),
        .head      (o_rdbuf_data),
        .level     (o_rdbuf_level),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_idli_sqi_rdbuf_m.sv
// Self-checking bench for idli_sqi_rdbuf_m: a 4x2 instance for the
// main scenarios and a 2x3 instance for pointer wrap streaming.
module tb_idli_sqi_rdbuf_m;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, sv, acp;
    logic [3:0]  sd;
    logic        rdy, vld, ovf;
    logic [15:0] data;
    logic [1:0]  level;

    logic        rst_nb, flushb, svb, acpb;
    logic [3:0]  sdb;
    logic        rdyb, vldb, ovfb;
    logic [7:0]  datab;
    logic [1:0]  levelb;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  expb_q[$];

    idli_sqi_rdbuf_m #(.NIBBLES(4), .DEPTH(2)) dut_a (
        .i_rdbuf_gck      (clk),
        .i_rdbuf_rst_n    (rst_n),
        .i_rdbuf_flush    (flush),
        .i_rdbuf_sqi_vld  (sv),
        .i_rdbuf_sqi_data (sd),
        .o_rdbuf_sqi_rdy  (rdy),
        .o_rdbuf_data     (data),
        .o_rdbuf_vld      (vld),
        .i_rdbuf_acp      (acp),
        .o_rdbuf_level    (level),
        .o_rdbuf_ovf      (ovf)
    );

    idli_sqi_rdbuf_m #(.NIBBLES(2), .DEPTH(3)) dut_b (
        .i_rdbuf_gck      (clk),
        .i_rdbuf_rst_n    (rst_nb),
        .i_rdbuf_flush    (flushb),
        .i_rdbuf_sqi_vld  (svb),
        .i_rdbuf_sqi_data (sdb),
        .o_rdbuf_sqi_rdy  (rdyb),
        .o_rdbuf_data     (datab),
        .o_rdbuf_vld      (vldb),
        .i_rdbuf_acp      (acpb),
        .o_rdbuf_level    (levelb),
        .o_rdbuf_ovf      (ovfb)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n, input logic a);
        sv = 1'b1; sd = n; acp = a;
        tick();
        sv = 1'b0; acp = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) send_nib(w[4*i +: 4], 1'b0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; sv = 1'b0; flush = 1'b0; acp = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; acp = 1'b0; sv = 1'b1; sd = 4'hF;
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", vld); end
        n_cmp++; if (level !== 2'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld2: got %b want 0", vld); end
        sv = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(16'hABCD);
        send_nib(4'hA, 1'b0);
        send_nib(4'hB, 1'b0);
        send_nib(4'hC, 1'b0);
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL b2b_early_vld: got %b want 0", vld); end
        send_nib(4'hD, 1'b0);
        n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL b2b_vld: got %b want 1", vld); end
        n_cmp++; if (data !== exp_q[0]) begin n_bad++; $display("FAIL b2b_data: got %h want %h", data, exp_q[0]); end
        n_cmp++; if (level !== 2'd1) begin n_bad++; $display("FAIL b2b_level: got %0d want 1", level); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy: got %b want 1", rdy); end
        acp = 1'b1;
        void'(exp_q.pop_front());
        tick();
        acp = 1'b0;
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL b2b_pop_vld: got %b want 0", vld); end
        n_cmp++; if (level !== 2'd0) begin n_bad++; $display("FAIL b2b_pop_level: got %0d want 0", level); end
    endtask

    task automatic test_gapped;
        int seq[7] = '{1, -1, 2, 3, -1, -1, 4};
        logic [15:0] e;
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 7; i++) begin
            sv = (seq[i] >= 0);
            sd = 4'(seq[i]);
            tick();
            sv = 1'b0;
            if (i < 6) begin
                n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL gap_early_vld%0d: got %b want 0", i, vld); end
            end
        end
        e = exp_q.pop_front();
        n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL gap_vld: got %b want 1", vld); end
        n_cmp++; if (data !== e) begin n_bad++; $display("FAIL gap_data: got %h want %h", data, e); end
        acp = 1'b1;
        tick();
        acp = 1'b0;
    endtask

    task automatic test_overflow;
        logic [15:0] e;
        do_reset();
        exp_q.delete();
        send_word(16'h1111); exp_q.push_back(16'h1111);
        send_word(16'h2222); exp_q.push_back(16'h2222);
        n_cmp++; if (level !== 2'd2) begin n_bad++; $display("FAIL ovf_full_level: got %0d want 2", level); end
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL ovf_full_rdy: got %b want 0", rdy); end
        send_word(16'h3333);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_cmp++; if (data !== exp_q[0]) begin n_bad++; $display("FAIL ovf_head: got %h want %h", data, exp_q[0]); end
        n_cmp++; if (level !== 2'd2) begin n_bad++; $display("FAIL ovf_level: got %0d want 2", level); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL ovf_flush_vld: got %b want 0", vld); end
        do_reset();
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_reset: got %b want 0", ovf); end
        send_word(16'h1111); exp_q.push_back(16'h1111);
        send_word(16'h2222); exp_q.push_back(16'h2222);
        send_nib(4'h3, 1'b0);
        send_nib(4'h3, 1'b0);
        send_nib(4'h3, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (data !== e) begin n_bad++; $display("FAIL pp_head: got %h want %h", data, e); end
        send_nib(4'h3, 1'b1);
        exp_q.push_back(16'h3333);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL pp_ovf: got %b want 0", ovf); end
        n_cmp++; if (data !== exp_q[0]) begin n_bad++; $display("FAIL pp_new_head: got %h want %h", data, exp_q[0]); end
        n_cmp++; if (level !== 2'd2) begin n_bad++; $display("FAIL pp_level: got %0d want 2", level); end
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            acp = 1'b1;
            n_cmp++; if (vld !== 1'b1 || data !== e) begin n_bad++; $display("FAIL pp_drain%0d: got %b/%h want 1/%h", k, vld, data, e); end
            tick();
        end
        acp = 1'b0;
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL pp_empty: got %b want 0", vld); end
    endtask

    task automatic test_flush;
        logic [15:0] e;
        do_reset();
        exp_q.delete();
        send_word(16'hABCD);
        send_nib(4'hE, 1'b0);
        send_nib(4'hF, 1'b0);
        flush = 1'b1; sv = 1'b1; sd = 4'h9; acp = 1'b1;
        tick();
        flush = 1'b0; sv = 1'b0; acp = 1'b0;
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL flush_vld: got %b want 0", vld); end
        n_cmp++; if (level !== 2'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", level); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL flush_rdy: got %b want 1", rdy); end
        exp_q.push_back(16'h5678);
        send_word(16'h5678);
        e = exp_q.pop_front();
        n_cmp++; if (data !== e) begin n_bad++; $display("FAIL flush_after: got %h want %h", data, e); end
        n_cmp++; if (level !== 2'd1) begin n_bad++; $display("FAIL flush_after_lvl: got %0d want 1", level); end
        send_nib(4'h1, 1'b0);
        send_nib(4'h2, 1'b0);
        do_reset();
        n_cmp++; if (vld !== 1'b0 || level !== 2'd0) begin n_bad++; $display("FAIL midrst: got %b/%0d want 0/0", vld, level); end
        exp_q.push_back(16'h3456);
        send_word(16'h3456);
        e = exp_q.pop_front();
        n_cmp++; if (data !== e) begin n_bad++; $display("FAIL midrst_word: got %h want %h", data, e); end
    endtask

    task automatic test_wrap;
        int b = 1;
        int ph = 0;
        int cyc = 0;
        int got = 0;
        logic [7:0] byte_v;
        logic [7:0] e;
        rst_nb = 1'b0; flushb = 1'b0; svb = 1'b0; sdb = 4'h0; acpb = 1'b0;
        tick();
        tick();
        rst_nb = 1'b1;
        while ((b <= 10 || expb_q.size() > 0) && cyc < 200) begin
            acpb = (cyc % 2 == 0);
            svb = 1'b0;
            if (vldb && acpb) begin
                n_cmp++;
                if (expb_q.size() == 0) begin
                    n_bad++; $display("FAIL wrap_extra: got %h want none", datab);
                end else begin
                    e = expb_q.pop_front();
                    got++;
                    if (datab !== e) begin n_bad++; $display("FAIL wrap_data: got %h want %h", datab, e); end
                end
            end
            if (b <= 10 && (ph == 1 || rdyb)) begin
                byte_v = 8'(b);
                svb = 1'b1;
                sdb = (ph == 0) ? byte_v[7:4] : byte_v[3:0];
                if (ph == 1) expb_q.push_back(byte_v);
            end
            tick();
            if (svb) begin
                if (ph == 1) begin ph = 0; b++; end
                else ph = 1;
            end
            cyc++;
            n_cmp++; if (levelb !== 2'(expb_q.size())) begin n_bad++; $display("FAIL wrap_level: got %0d want %0d", levelb, expb_q.size()); end
        end
        svb = 1'b0; acpb = 1'b0;
        n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL wrap_timeout: got %0d cycles want <200", cyc); end
        n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL wrap_count: got %0d want 10", got); end
        n_cmp++; if (ovfb !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf: got %b want 0", ovfb); end
        n_cmp++; if (vldb !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: got %b want 0", vldb); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; sv = 1'b0; sd = 4'h0; acp = 1'b0;
        rst_nb = 1'b0; flushb = 1'b0; svb = 1'b0; sdb = 4'h0; acpb = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_overflow();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
